// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump reader: FSM encoding and the register file
// geometry defaults used by both the reader and the register file.
package reg_dump_pkg;

  localparam int unsigned NumRegsDefault = 32;
  localparam int unsigned AddrWDefault   = 5;
  localparam int unsigned DataWDefault   = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StHold = 2'd2,
    StFin  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/dump_period_counter.sv
// Free-running period counter: pulses Trigger for one cycle every DUMP_PERIOD cycles.
// Instantiated by reg_dump_reader only when REG_DUMP_AUTO_EN is defined.
module dump_period_counter #(
  parameter int unsigned DUMP_PERIOD = 100
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic Trigger
);

  localparam int unsigned CntW = (DUMP_PERIOD > 1) ? $clog2(DUMP_PERIOD) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign Trigger = (cnt_q == CntW'(DUMP_PERIOD - 1));
  assign cnt_d   = Trigger ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks every register through one register-file read port and streams (index, value)
// over a valid/ready handshake. Define REG_DUMP_AUTO_EN to add a periodic self-trigger.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NumRegsDefault,
  parameter int unsigned ADDR_W      = AddrWDefault,
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned DUMP_PERIOD = 100
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  output logic [ADDR_W-1:0] Read_Register,
  input  logic [DATA_W-1:0] Read_Data,
  output logic              Dump_Valid,
  input  logic              Dump_Ready,
  output logic [ADDR_W-1:0] Dump_Index,
  output logic [DATA_W-1:0] Dump_Data,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  if (((2 ** ADDR_W) < NUM_REGS) || (DUMP_PERIOD == 0)) begin : g_param_check
    $error("reg_dump_reader: ADDR_W too narrow for NUM_REGS or DUMP_PERIOD is zero");
  end

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_index_q, dump_index_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              start_req;

`ifdef REG_DUMP_AUTO_EN
  logic auto_trigger;

  dump_period_counter #(
    .DUMP_PERIOD(DUMP_PERIOD)
  ) u_period_counter (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Trigger(auto_trigger)
  );

  // A trigger landing mid-dump is dropped because start_req is only looked at in idle.
  assign start_req = Start | auto_trigger;
`else
  assign start_req = Start;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_index_d = dump_index_q;
    dump_data_d  = dump_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StRead;
          idx_d   = '0;
        end
      end
      StRead: begin
        // Read is combinational, so this captures the value from before any same-edge write.
        dump_data_d  = Read_Data;
        dump_index_d = idx_q;
        state_d      = StHold;
      end
      StHold: begin
        if (Dump_Ready) begin
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StRead;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dump_index_q <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_index_q <= dump_index_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign Read_Register = idx_q;
  assign Dump_Valid    = (state_q == StHold);
  assign Dump_Index    = dump_index_q;
  assign Dump_Data     = dump_data_q;
  assign Busy          = (state_q == StRead) || (state_q == StHold);
  assign Done          = (state_q == StFin);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed-plus-random bench for reg_dump_reader with a behavioural register file and an
// expected dump derived from a snapshot of the register contents at dump start.
module tb_reg_dump_reader;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  logic              Clock      = 1'b0;
  logic              Reset_n    = 1'b0;
  logic              Start      = 1'b0;
  logic              Dump_Ready = 1'b0;
  logic [ADDR_W-1:0] Read_Register;
  logic [DATA_W-1:0] Read_Data;
  logic              Dump_Valid;
  logic [ADDR_W-1:0] Dump_Index;
  logic [DATA_W-1:0] Dump_Data;
  logic              Busy;
  logic              Done;

  // Behavioural register file: combinational read, write at posedge.
  logic [DATA_W-1:0] rf       [NUM_REGS];
  logic [DATA_W-1:0] load_val [NUM_REGS];
  logic              load_en = 1'b0;
  logic              we      = 1'b0;
  logic [ADDR_W-1:0] waddr   = '0;
  logic [DATA_W-1:0] wdata   = '0;

  int cyc    = 0;
  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (load_en) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= load_val[i];
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign Read_Data = rf[Read_Register];

  reg_dump_reader #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DUMP_PERIOD(100)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Read_Register(Read_Register),
    .Read_Data    (Read_Data),
    .Dump_Valid   (Dump_Valid),
    .Dump_Ready   (Dump_Ready),
    .Dump_Index   (Dump_Index),
    .Dump_Data    (Dump_Data),
    .Busy         (Busy),
    .Done         (Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // mode 0: reg[i] = i, mode 1: random contents
  task automatic load_regs(input int mode);
    for (int i = 0; i < NUM_REGS; i++) load_val[i] = (mode == 0) ? i : $urandom;
    load_en = 1'b1;
    @(posedge Clock);
    #1;
    load_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " Read_Register"}, 32'(Read_Register), 32'd0);
    check({tag, " Dump_Valid"}, 32'(Dump_Valid), 32'd0);
    check({tag, " Dump_Index"}, 32'(Dump_Index), 32'd0);
    check({tag, " Dump_Data"}, Dump_Data, 32'd0);
    check({tag, " Busy"}, 32'(Busy), 32'd0);
    check({tag, " Done"}, 32'(Done), 32'd0);
  endtask

  // One full dump; -1 disables the stall / restart / write feature.
  task automatic run_dump(input string name, input int stall_idx, input int restart_idx,
                          input int write_idx, input logic [31:0] write_val);
    logic [31:0] expv [NUM_REGS];
    int          got_idx [$];
    logic [31:0] got_dat [$];
    int          start_cyc, first_valid_cyc, done_cyc, stall_cnt;
    bit          done_seen;
    for (int i = 0; i < NUM_REGS; i++) expv[i] = rf[i];
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_seen       = 1'b0;
    stall_cnt       = 0;
    Start           = 1'b1;
    start_cyc       = cyc;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      @(posedge Clock);
      #1;
      Start = 1'b0;
      we    = 1'b0;
      if (Done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check({name, " Busy low with Done"}, 32'(Busy), 32'd0);
      end else if (Dump_Valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (Dump_Index == stall_idx && stall_cnt == 0) begin
          Dump_Ready = 1'b0;
          repeat (5) begin
            @(posedge Clock);
            #1;
            stall_cnt++;
            check({name, " stall valid"}, 32'(Dump_Valid), 32'd1);
            check({name, " stall index"}, 32'(Dump_Index), 32'(stall_idx));
            check({name, " stall data"}, Dump_Data, expv[stall_idx]);
          end
        end
        Dump_Ready = 1'b1;
        got_idx.push_back(int'(Dump_Index));
        got_dat.push_back(Dump_Data);
        if (Dump_Index == restart_idx) Start = 1'b1;
      end else begin
        Dump_Ready = 1'($urandom_range(0, 1));
        if (Busy && Read_Register == write_idx) begin
          we    = 1'b1;
          waddr = ADDR_W'(write_idx);
          wdata = write_val;
        end
      end
    end
    Dump_Ready = 1'b0;
    check({name, " done seen"}, 32'(done_seen), 32'd1);
    check({name, " first valid latency"}, 32'(first_valid_cyc - start_cyc), 32'd2);
    if (done_seen) begin
      check({name, " done latency"}, 32'(done_cyc - start_cyc),
            32'(2 * NUM_REGS + 1 + stall_cnt));
    end
    check({name, " element count"}, 32'(got_idx.size()), NUM_REGS);
    for (int i = 0; i < NUM_REGS && i < got_idx.size(); i++) begin
      check($sformatf("%s idx[%0d]", name, i), 32'(got_idx[i]), 32'(i));
      check($sformatf("%s data[%0d]", name, i), got_dat[i], expv[i]);
    end
    repeat (3) begin
      @(posedge Clock);
      #1;
      check({name, " single Done"}, 32'(Done), 32'd0);
      check({name, " idle Busy"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    int busy_cycles;
    bit reached;

    // Reset values while held in reset.
    load_regs(0);
    #2;
    check_reset_outputs("reset");
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    // With Start low the reader must stay idle; only the auto build dumps by itself.
    busy_cycles = 0;
    repeat (150) begin
      @(posedge Clock);
      #1;
      if (Busy) busy_cycles++;
    end
`ifndef REG_DUMP_AUTO_EN
    check("no dump without Start", 32'(busy_cycles), 32'd0);
`endif

    load_regs(0);
    run_dump("plain", -1, -1, -1, 32'd0);

    load_regs(1);
    run_dump("stall7", 7, -1, -1, 32'd0);

    run_dump("restart10", -1, 10, -1, 32'd0);

    load_regs(0);
    run_dump("write3", -1, -1, 3, 32'hDEADBEEF);
    check("reg3 written", rf[3], 32'hDEADBEEF);
    run_dump("after write", -1, -1, -1, 32'd0);

    // Abort mid-dump with an asynchronous reset.
    load_regs(1);
    Start   = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(posedge Clock);
      #1;
      Start      = 1'b0;
      Dump_Ready = 1'b1;
      if (Dump_Valid && Dump_Index == 12) reached = 1'b1;
    end
    check("reached index 12", 32'(reached), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    Dump_Ready = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      check("no Done in reset", 32'(Done), 32'd0);
    end
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    run_dump("post-abort", -1, -1, -1, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
